// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Purpose : instruction-memory request/response bundle between the fetch
//           unit (master) and the instruction memory (slave).
// Signals :
//   imem_req    master->slave  request valid
//   imem_addr   master->slave  word-aligned fetch address (32b)
//   imem_ready  slave->master  data returned this cycle
//   imem_rdata  slave->master  instruction word (32b), valid with req & ready
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Purpose : instruction-fetch front end. Owns the program counter, drives the
//           instruction-memory handshake and keeps one fetched instruction in
//           a buffer that feeds the IF/ID pipeline register. Freeze holds the
//           buffered instruction; branch_taken flushes it and redirects.
// Parameters:
//   RESET_PC      first fetch address after reset
//   PC_INC        byte increment per sequential fetch
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   freeze        hazard stall from ID, holds the buffered instruction
//   branch_taken  redirect/flush from EXE
//   branch_addr   redirect target, bits [1:0] ignored
//   imem          instruction-memory bundle (master modport)
//   PC            fetch address + PC_INC of buffered instruction
//   Instruction   buffered instruction word (0 = bubble)
//   if_valid      PC/Instruction hold a real instruction
// Optional build macro:
//   FETCH_PERF_CNT_EN  adds perf_fetched (buffer loads) and perf_stall
//                      (cycles with freeze while the buffer is full)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_addr,
    if_fetch_unit_if.master       imem,
    output logic [31:0]           PC,
    output logic [31:0]           Instruction,
    output logic                  if_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] dropAddr_q, dropAddr_d;
    logic        pending_q, pending_d;
    logic        bufValid_q, bufValid_d;
    logic [31:0] bufPc_q, bufPc_d;
    logic [31:0] bufInstr_q, bufInstr_d;

    logic        reqRaw;
    logic [31:0] addrRaw;
    logic        loadBuf;
    logic        consume;
    logic        unusedBranchLsbs;

    // The two low target bits are forced to zero, so they never reach logic.
    assign unusedBranchLsbs = ^branch_addr[1:0];

    assign consume = bufValid_q && !freeze;

    // Next-state and handshake logic. A new request is not started while the
    // buffer is full and frozen (it would have nowhere to land), but once a
    // request has been issued (pending_q) it is held until imem_ready.
    // A pending request always implies an empty buffer, so every accepted
    // response in REQ can be loaded.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        dropAddr_d = dropAddr_q;
        pending_d  = 1'b0;
        bufValid_d = bufValid_q;
        bufPc_d    = bufPc_q;
        bufInstr_d = bufInstr_q;
        reqRaw     = 1'b0;
        addrRaw    = pc_q;
        loadBuf    = 1'b0;

        case (state_q)
            IDLE: begin
                if (branch_taken || !freeze) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                reqRaw = pending_q || !(bufValid_q && freeze);
                if (branch_taken) begin
                    dropAddr_d = pc_q;
                    state_d    = (reqRaw && !imem.imem_ready) ? DROP : REQ;
                end else if (reqRaw && imem.imem_ready) begin
                    loadBuf = 1'b1;
                    pc_d    = pc_q + PC_INC;
                    state_d = freeze ? IDLE : REQ;
                end else if (reqRaw) begin
                    pending_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                // Finish the abandoned transaction at its old address and
                // throw the data away; pc_q already holds the redirect target.
                reqRaw  = 1'b1;
                addrRaw = dropAddr_q;
                if (!branch_taken && imem.imem_ready) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        if (branch_taken) begin
            pc_d = {branch_addr[31:2], 2'b00};
        end

        // Buffer update: flush beats load, load beats plain consumption.
        // An empty buffer reads as all zeroes so it presents a bubble.
        if (branch_taken) begin
            bufValid_d = 1'b0;
            bufPc_d    = 32'h0;
            bufInstr_d = 32'h0;
        end else if (loadBuf) begin
            bufValid_d = 1'b1;
            bufPc_d    = pc_q + PC_INC;
            bufInstr_d = imem.imem_rdata;
        end else if (consume) begin
            bufValid_d = 1'b0;
            bufPc_d    = 32'h0;
            bufInstr_d = 32'h0;
        end
    end

    // State and buffer registers with synchronous reset; reset drops any
    // outstanding transaction without passing through DROP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            dropAddr_q <= 32'h0;
            pending_q  <= 1'b0;
            bufValid_q <= 1'b0;
            bufPc_q    <= 32'h0;
            bufInstr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            dropAddr_q <= dropAddr_d;
            pending_q  <= pending_d;
            bufValid_q <= bufValid_d;
            bufPc_q    <= bufPc_d;
            bufInstr_q <= bufInstr_d;
        end
    end

    assign imem.imem_req  = reqRaw && !rst;
    assign imem.imem_addr = addrRaw;
    assign PC             = bufPc_q;
    assign Instruction    = bufInstr_q;
    assign if_valid       = bufValid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfFetched_q;
    logic [31:0] perfStall_q;

    // Fetched counts only loads that survived (loadBuf is never set with a
    // branch); stall counts cycles where a held instruction is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            perfFetched_q <= 32'h0;
            perfStall_q   <= 32'h0;
        end else begin
            if (loadBuf) begin
                perfFetched_q <= perfFetched_q + 32'd1;
            end
            if (freeze && bufValid_q) begin
                perfStall_q <= perfStall_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perfFetched_q;
    assign perf_stall   = perfStall_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Purpose : self-checking bench for if_fetch_unit. A table of per-cycle
//           inputs and hand-computed outputs is applied one cycle at a time;
//           a short hand-written sequence covers a branch arriving while
//           already dropping a transaction.
// Memory  : combinational, zero-latency data = address ^ 32'h1357_9BDF,
//           readiness driven from the vectors.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    typedef struct {
        logic        rst;
        logic        freeze;
        logic        branch;
        logic [31:0] branchAddr;
        logic        ready;
        logic        expReq;
        logic [31:0] expAddr;
        logic [31:0] expPc;
        logic        expValid;
    } vec_t;

    localparam int NUM_VECS = 33;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branchTaken;
    logic [31:0] branchAddr;
    logic [31:0] pcOut;
    logic [31:0] instrOut;
    logic        ifValid;

    int checks;
    int passes;

    vec_t vecs [NUM_VECS];

    if_fetch_unit_if imemBus ();

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_INC   (32'd4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branchTaken),
        .branch_addr  (branchAddr),
        .imem         (imemBus),
        .PC           (pcOut),
        .Instruction  (instrOut),
        .if_valid     (ifValid)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Instruction the buffer should show for a given output PC.
    function automatic logic [31:0] expInstr(input logic [31:0] pcVal, input logic valid);
        logic [31:0] fetchAddr;
        fetchAddr = pcVal - 32'd4;
        return valid ? memWord(fetchAddr) : 32'h0;
    endfunction

    assign imemBus.imem_rdata = memWord(imemBus.imem_addr);

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "[TB] timeout");
    end

    // Drive one cycle's inputs after the falling edge and let them settle
    task automatic applyStimulus(input logic r, input logic f, input logic b,
                                 input logic [31:0] ba, input logic rdy);
        @(negedge clk);
        rst                = r;
        freeze             = f;
        branchTaken        = b;
        branchAddr         = ba;
        imemBus.imem_ready = rdy;
        #1;
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic eReq, input logic [31:0] eAddr,
                               input logic [31:0] ePc, input logic eValid);
        checkField({tag, ".imem_req"},    {31'h0, imemBus.imem_req}, {31'h0, eReq});
        checkField({tag, ".imem_addr"},   imemBus.imem_addr, eAddr);
        checkField({tag, ".PC"},          pcOut, ePc);
        checkField({tag, ".Instruction"}, instrOut, expInstr(ePc, eValid));
        checkField({tag, ".if_valid"},    {31'h0, ifValid}, {31'h0, eValid});
    endtask

    initial begin
        checks = 0;
        passes = 0;

        // rst frz br  target        rdy | req  addr          PC            valid
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 32'h0000_0004, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0008, 32'h0000_0008, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0008, 32'h0000_0008, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0008, 32'h0000_0008, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0008, 32'h0000_0008, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0008, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_000C, 32'h0000_000C, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0010, 32'h0000_0010, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0010, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0010, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0014, 32'h0000_0014, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0018, 32'h0000_0018, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_001C, 32'h0000_001C, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0020, 32'h0000_0020, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0020, 32'h0000_0000, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0100, 32'h0000_0000, 1'b0};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0104, 32'h0000_0104, 1'b1};
        vecs[22] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_0104, 1'b1};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
        vecs[24] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[26] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[27] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0004, 32'h0000_0004, 1'b1};
        vecs[28] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0004, 32'h0000_0000, 1'b0};
        vecs[29] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0};
        vecs[30] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[31] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[32] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 32'h0000_0004, 1'b1};

        // Initial reset, unchecked while state is still unknown
        rst                = 1'b1;
        freeze             = 1'b0;
        branchTaken        = 1'b0;
        branchAddr         = 32'h0;
        imemBus.imem_ready = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].freeze, vecs[i].branch,
                          vecs[i].branchAddr, vecs[i].ready);
            checkOutput($sformatf("v%0d", i), vecs[i].expReq, vecs[i].expAddr,
                        vecs[i].expPc, vecs[i].expValid);
        end

        // Branch while already dropping: the second target wins and the
        // old address is finished before fetching resumes.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0,         1'b0);
        checkOutput("drop0", 1'b1, 32'h0000_0008, 32'h0000_0008, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
        checkOutput("drop1", 1'b1, 32'h0000_0008, 32'h0000_0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0302, 1'b0);
        checkOutput("drop2", 1'b1, 32'h0000_0008, 32'h0000_0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0,         1'b1);
        checkOutput("drop3", 1'b1, 32'h0000_0008, 32'h0000_0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0,         1'b1);
        checkOutput("drop4", 1'b1, 32'h0000_0300, 32'h0000_0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0,         1'b1);
        checkOutput("drop5", 1'b1, 32'h0000_0304, 32'h0000_0304, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
